// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared TDM line constants and framing state encoding
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  // Shared with the 4:1 transmitter, so the encoding is fixed explicitly
  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } tdm_state_t;

endpackage

// File: rtl/tdm_chan_sr.sv
// rtl/tdm_chan_sr.sv - one channel deserialising shift register (MSB first)
module tdm_chan_sr #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              d,
  output logic [WORD_W-1:0] word_next
);

  logic [WORD_W-1:0] q;

  // Clear together with shift starts a fresh word with d as its first bit
  always_comb begin
    word_next = q;
    if (clr) begin
      word_next = shift_en ? {{(WORD_W-1){1'b0}}, d} : '0;
    end else if (shift_en) begin
      word_next = {q[WORD_W-2:0], d};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= word_next;
    end
  end

endmodule

// File: rtl/tdm_demux1to4.sv
// rtl/tdm_demux1to4.sv - 1:4 TDM receive demultiplexer; TDM_DEMUX_ERR_EN builds the sticky ERR register
module tdm_demux1to4
  import tdm_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              D,
  input  logic              FS,
  output logic [WORD_W-1:0] O0,
  output logic [WORD_W-1:0] O1,
  output logic [WORD_W-1:0] O2,
  output logic [WORD_W-1:0] O3,
  output logic              V,
  output logic [SLOT_W-1:0] S,
  output logic              LOCK,
  output logic              ERR
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_W - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

  tdm_state_t        state_q, state_d;
  logic [SLOT_W-1:0] slot_q;
  logic [CNT_W-1:0]  bit_q;
  logic              first_q;
  logic              acquire, resync, miss, word_done, sr_clr;
  logic [NUM_CH-1:0] shift_en;
  logic [WORD_W-1:0] word_next [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT: if (FS) state_d = ST_LOCK;
      ST_LOCK: if (miss) state_d = ST_HUNT;
      default: state_d = ST_HUNT;
    endcase
  end

  always_comb begin
    acquire   = (state_q == ST_HUNT) && FS;
    resync    = (state_q == ST_LOCK) && FS && (slot_q != '0);
    // The first frame boundary after acquisition tolerates an absent sync
    miss      = (state_q == ST_LOCK) && !FS && (slot_q == '0) && !first_q;
    word_done = (state_q == ST_LOCK) && !FS && (slot_q == LAST_SLOT) && (bit_q == LAST_BIT);
    sr_clr    = acquire || resync || miss;
    shift_en  = '0;
    if (acquire || resync) begin
      shift_en[0] = 1'b1;
    end else if ((state_q == ST_LOCK) && !miss) begin
      shift_en[slot_q] = 1'b1;
    end
    LOCK = (state_q == ST_LOCK);
    S    = slot_q;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tdm_chan_sr #(.WORD_W(WORD_W)) u_sr (
      .clk       (clk),
      .rst       (rst),
      .clr       (sr_clr),
      .shift_en  (shift_en[c]),
      .d         (D),
      .word_next (word_next[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= '0;
      bit_q   <= '0;
      first_q <= 1'b0;
    end else if (acquire || resync) begin
      slot_q  <= SLOT_W'(1);
      bit_q   <= '0;
      if (acquire) first_q <= 1'b1;
    end else if (miss) begin
      slot_q  <= '0;
      bit_q   <= '0;
      first_q <= 1'b0;
    end else if (state_q == ST_LOCK) begin
      slot_q <= slot_q + SLOT_W'(1);
      if (slot_q == '0) first_q <= 1'b0;
      if (slot_q == LAST_SLOT) begin
        bit_q <= (bit_q == LAST_BIT) ? '0 : bit_q + CNT_W'(1);
      end
    end
  end

  // Channel 3's word_next already contains this cycle's LSB
  always_ff @(posedge clk) begin
    if (rst) begin
      O0 <= '0;
      O1 <= '0;
      O2 <= '0;
      O3 <= '0;
      V  <= 1'b0;
    end else begin
      V <= word_done;
      if (word_done) begin
        O0 <= word_next[0];
        O1 <= word_next[1];
        O2 <= word_next[2];
        O3 <= word_next[3];
      end
    end
  end

`ifdef TDM_DEMUX_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (resync || miss) begin
      err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule
